// File: rtl/line_xfer_ctl.sv
// Cache-line transfer engine: one 16-byte line read/write to four 32-bit bus beats.
// Optional statistics counters are built when LINE_XFER_STATS_EN is defined.
module line_xfer_ctl #(
   parameter int LINE_WORDS = 4
) (
   input  logic         clk_core,
   input  logic         reset_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_write,
   input  logic [27:4]  req_addr,
   input  logic [127:0] req_wdata,
   input  logic [15:0]  req_wmask,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [127:0] resp_rdata,
   output logic         resp_error,
   output logic         bus_cvalid,
   input  logic         bus_cready,
   output logic         bus_cmd,
   output logic [27:2]  bus_addr,
   output logic         bus_wvalid,
   input  logic         bus_wready,
   output logic         bus_wlast,
   output logic [31:0]  bus_wdata,
   output logic [3:0]   bus_wmask,
   input  logic         bus_rvalid,
   output logic         bus_rready,
   input  logic         bus_rlast,
   input  logic [31:0]  bus_rdata,
   input  logic         bus_error,
   output logic [31:0]  stat_reads,
   output logic [31:0]  stat_writes,
   output logic [31:0]  stat_busy
);

   localparam logic [2:0] LAST = 3'(LINE_WORDS - 1);
   localparam logic [2:0] FULL = 3'(LINE_WORDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RCMD,
      S_RDATA,
      S_WXFER,
      S_RESP
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [27:4]    r_addr;
   logic [127:0]   r_wdata;
   logic [15:0]    r_wmask;
   logic [127:0]   r_buf;
   logic           r_err;
   logic [2:0]     r_beat;
   logic           r_cmd_done;
   logic [1:0]     w_widx;
   logic           w_cmd_ok;
   logic           w_dat_ok;

   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      bus_cvalid = 1'b0;
      bus_cmd    = 1'b0;
      bus_wvalid = 1'b0;
      bus_rready = 1'b0;
      resp_valid = 1'b0;
      w_cmd_ok   = 1'b0;
      w_dat_ok   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               w_next = req_write ? S_WXFER : S_RCMD;
         end
         S_RCMD: begin
            bus_cvalid = 1'b1;
            bus_cmd    = 1'b1;
            if (bus_cready)
               w_next = S_RDATA;
         end
         S_RDATA: begin
            bus_rready = 1'b1;
            if (bus_rvalid && (bus_rlast || r_beat == LAST))
               w_next = S_RESP;
         end
         S_WXFER: begin
            bus_cvalid = !r_cmd_done;
            bus_wvalid = (r_beat != FULL);
            // command and data may both finish in this same cycle
            w_cmd_ok = r_cmd_done || bus_cready;
            w_dat_ok = (r_beat == FULL) ||
                       (r_beat == LAST && bus_wready);
            if (w_cmd_ok && w_dat_ok)
               w_next = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_widx     = r_beat[1:0];
   assign bus_addr   = {r_addr, 2'b00};
   assign bus_wdata  = bus_wvalid ? r_wdata[{w_widx, 5'b0} +: 32] : '0;
   assign bus_wmask  = bus_wvalid ? r_wmask[{w_widx, 2'b0} +: 4] : '0;
   assign bus_wlast  = bus_wvalid && (r_beat == LAST);
   assign resp_rdata = resp_valid ? r_buf : '0;
   assign resp_error = resp_valid && r_err;

   always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wmask    <= '0;
         r_buf      <= '0;
         r_err      <= 1'b0;
         r_beat     <= '0;
         r_cmd_done <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE) begin
            if (req_valid) begin
               r_addr     <= req_addr;
               r_wdata    <= req_wdata;
               r_wmask    <= req_wmask;
               r_buf      <= '0;
               r_err      <= 1'b0;
               r_beat     <= '0;
               r_cmd_done <= 1'b0;
            end
         end else begin
            if (bus_error)
               r_err <= 1'b1;
            if (r_state == S_RDATA && bus_rvalid) begin
               r_buf[{w_widx, 5'b0} +: 32] <= bus_rdata;
               r_beat <= r_beat + 3'd1;
               // short burst, or a full burst missing its last flag
               if (bus_rlast != (r_beat == LAST))
                  r_err <= 1'b1;
            end
            if (r_state == S_WXFER) begin
               if (bus_cvalid && bus_cready)
                  r_cmd_done <= 1'b1;
               if (bus_wvalid && bus_wready)
                  r_beat <= r_beat + 3'd1;
            end
         end
      end
   end

`ifdef LINE_XFER_STATS_EN
   logic [31:0] r_st_rd;
   logic [31:0] r_st_wr;
   logic [31:0] r_st_busy;
   logic        r_is_wr;

   always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) begin
         r_st_rd   <= '0;
         r_st_wr   <= '0;
         r_st_busy <= '0;
         r_is_wr   <= 1'b0;
      end else begin
         if (r_state == S_IDLE && req_valid)
            r_is_wr <= req_write;
         if (r_state != S_IDLE)
            r_st_busy <= r_st_busy + 32'd1;
         if (resp_valid && resp_ready) begin
            if (r_is_wr)
               r_st_wr <= r_st_wr + 32'd1;
            else
               r_st_rd <= r_st_rd + 32'd1;
         end
      end
   end

   assign stat_reads  = r_st_rd;
   assign stat_writes = r_st_wr;
   assign stat_busy   = r_st_busy;
`else
   assign stat_reads  = '0;
   assign stat_writes = '0;
   assign stat_busy   = '0;
`endif

endmodule
